// File: rtl/beamform_pkg.sv
// Shared types and default sizing for the delay-and-sum beamformer.
package beamform_pkg;

    localparam int unsigned BF_MICS      = 2;
    localparam int unsigned BF_SAMPLE_W  = 24;
    localparam int unsigned BF_MAX_DELAY = 16;

    typedef logic signed [BF_SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {IDLE, WRITE, SUM, DONE} bf_state_t;

endpackage

// File: rtl/sample_history_ram.sv
// Per-mic circular sample history: one bank per mic written together, one synchronous read port
// addressed {mic, ptr}.
module sample_history_ram #(
    parameter int unsigned MICS     = 2,
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned DEPTH    = 16,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned MIC_W   = (MICS > 1) ? $clog2(MICS) : 1
) (
    input  logic                          clk_in,
    input  logic                          wr_en,
    input  logic [PTR_W-1:0]              wr_ptr,
    input  logic [MICS-1:0][SAMPLE_W-1:0] wr_data,
    input  logic                          rd_en,
    input  logic [MIC_W-1:0]              rd_mic,
    input  logic [PTR_W-1:0]              rd_ptr,
    output logic [SAMPLE_W-1:0]           rd_data
);

    logic [SAMPLE_W-1:0] mem [MICS][DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            for (int m = 0; m < MICS; m++) begin
                mem[m][wr_ptr] <= wr_data[m];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_mic][rd_ptr];
        end
    end

endmodule

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum stage: stores each TDM frame into per-mic history, then sums one delayed
// sample per mic and emits the sum plus a scaled copy at input width.
module delay_sum_beamformer
    import beamform_pkg::*;
#(
    parameter int unsigned MICS      = BF_MICS,
    parameter int unsigned SAMPLE_W  = BF_SAMPLE_W,
    parameter int unsigned MAX_DELAY = BF_MAX_DELAY,
    localparam int unsigned DLY_W    = $clog2(MAX_DELAY),
    localparam int unsigned SUM_W    = SAMPLE_W + $clog2(MICS)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [MICS-1:0][SAMPLE_W-1:0] audio_in,
    input  logic                          audio_valid_in,
    input  logic [MICS-1:0][DLY_W-1:0]    delay_in,
    output logic signed [SUM_W-1:0]       sum_out,
    output logic [SAMPLE_W-1:0]           scaled_out,
    output logic                          sum_valid_out,
    output logic                          busy_out,
    output logic                          drop_out
);

    localparam int unsigned   MIC_W    = (MICS > 1) ? $clog2(MICS) : 1;
    localparam int unsigned   SHIFT    = $clog2(MICS);
    localparam logic [DLY_W:0] FILL_MAX = (DLY_W + 1)'(MAX_DELAY);
    localparam logic [MIC_W-1:0] LAST_MIC = MIC_W'(MICS - 1);

    bf_state_t state_q, state_d;

    logic                       valid_q, prev_q, rise;
    logic [MIC_W-1:0]           cnt_q;
    logic [DLY_W-1:0]           wp_q;
    logic [DLY_W:0]             fill_q;
    logic [MICS-1:0][DLY_W-1:0] dly_q;
    logic signed [SUM_W-1:0]    acc_q, acc_sum, term, sum_q;
    logic [SAMPLE_W-1:0]        scaled_q;
    logic                       rd_pend_q, rd_mask_q, sum_valid_q, drop_q;
    logic                       ram_we, ram_re, term_mask;
    logic [DLY_W-1:0]           cur_dly, rd_ptr;
    logic [SAMPLE_W-1:0]        rd_data;

    // Edge detect runs on the registered copy so the frame start is a clean one-cycle event.
    assign rise = valid_q & ~prev_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = WRITE;
            WRITE:   state_d = SUM;
            SUM:     if (cnt_q == LAST_MIC) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_out  = (state_q != IDLE);
        ram_we    = (state_q == WRITE);
        ram_re    = (state_q == SUM);
        cur_dly   = dly_q[cnt_q];
        rd_ptr    = wp_q - cur_dly;
        // A delay reaching past the frames written since reset reads stale memory; mask it.
        term_mask = ({1'b0, cur_dly} >= fill_q);
    end

    always_comb begin
        if (rd_mask_q) begin
            term = '0;
        end else begin
            term = SUM_W'($signed(rd_data));
        end
        if (rd_pend_q) begin
            acc_sum = acc_q + term;
        end else begin
            acc_sum = acc_q;
        end
    end

    sample_history_ram #(
        .MICS     (MICS),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (MAX_DELAY)
    ) u_hist (
        .clk_in  (clk_in),
        .wr_en   (ram_we),
        .wr_ptr  (wp_q),
        .wr_data (audio_in),
        .rd_en   (ram_re),
        .rd_mic  (cnt_q),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            wp_q        <= '0;
            fill_q      <= '0;
            dly_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            scaled_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_mask_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            valid_q     <= audio_valid_in;
            prev_q      <= valid_q;
            drop_q      <= rise && (state_q != IDLE);
            sum_valid_q <= (state_q == DONE);
            rd_pend_q   <= ram_re;
            rd_mask_q   <= term_mask;
            acc_q       <= acc_sum;
            case (state_q)
                WRITE: begin
                    dly_q  <= delay_in;
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    fill_q <= (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                end
                SUM: cnt_q <= cnt_q + 1'b1;
                DONE: begin
                    sum_q    <= acc_sum;
                    scaled_q <= SAMPLE_W'(acc_sum >>> SHIFT);
                    wp_q     <= wp_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum_out       = sum_q;
    assign scaled_out    = scaled_q;
    assign sum_valid_out = sum_valid_q;
    assign drop_out      = drop_q;

endmodule
